// File: rtl/tick_divider_if.sv
// tick_divider_if
//   Bundle of the control and status signals of the tick_divider block.
//   master : the consumer/controller side (drives run, sync_clr, divisor writes;
//            observes ticks, square waves, pending flags and the free-running count)
//   slave  : the tick_divider itself
//   Signals:
//     run[NUM_CH]       per-channel count enable
//     sync_clr          restart all channels together
//     div_we/div_sel    divisor write strobe and channel address
//     div_data          new divisor value
//     tick[NUM_CH]      one-cycle enable per channel
//     sq[NUM_CH]        square wave per channel (toggles on each tick)
//     pending[NUM_CH]   written divisor not yet in effect
//     free_cnt          free-running cycle counter
interface tick_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 26,
  parameter int FREE_W = 32,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] run;
  logic              sync_clr;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_data;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] pending;
  logic [FREE_W-1:0] free_cnt;

  modport master (
    output run, sync_clr, div_we, div_sel, div_data,
    input  tick, sq, pending, free_cnt
  );

  modport slave (
    input  run, sync_clr, div_we, div_sel, div_data,
    output tick, sq, pending, free_cnt
  );
endinterface

// File: rtl/tick_divider.sv
// tick_divider
//   Multi-channel programmable clock-enable generator. Each channel produces a
//   registered one-cycle tick every Deff run-enabled cycles (Deff = D, or 1 when
//   D is 0) and a square wave that toggles on every tick. Divisor writes go to a
//   shadow register and only take effect at the channel's next wrap or at a
//   sync_clr, so a running period is never shortened or stretched.
//   A free-running counter is kept for legacy divided-clock taps.
//   Ports:
//     clk    system clock, all logic on posedge
//     reset  synchronous, active-high reset (priority over everything)
//     bus    tick_divider_if slave modport (controls in, ticks/status out)
module tick_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 25_000_000,
  parameter int FREE_W      = 32
) (
  input  logic           clk,
  input  logic           reset,
  tick_divider_if.slave  bus
);

  localparam int               SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Free-running counter, independent of run and sync_clr.
  logic [FREE_W-1:0] free_q;
  logic [FREE_W-1:0] free_d;

  assign free_d = free_q + FREE_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      free_q <= '0;
    end else begin
      free_q <= free_d;
    end
  end

  assign bus.free_cnt = free_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic [CNT_W-1:0] last_cnt;
    logic             wrap;
    logic             wr_hit;

    // D==0 behaves as D==1, so the terminal count is 0 in both cases.
    assign last_cnt = (div_q == '0) ? '0 : (div_q - CNT_ONE);
    assign wrap     = (cnt_q == last_cnt);
    // div_sel matching a channel index implies it is in range; out-of-range
    // selects simply hit no channel.
    assign wr_hit   = bus.div_we && (bus.div_sel == SEL_W'(gi));

    always_comb begin
      cnt_d     = cnt_q;
      div_d     = div_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      tick_d    = 1'b0;
      sq_d      = sq_q;

      if (bus.sync_clr) begin
        cnt_d = '0;
        sq_d  = 1'b0;
        if (pending_q) begin
          div_d = shadow_q;
        end
        pending_d = 1'b0;
      end else if (bus.run[gi]) begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          sq_d   = ~sq_q;
          if (pending_q) begin
            div_d     = shadow_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A write on the same edge as an apply: the apply above used the old
      // shadow; the new value waits for the next wrap or sync_clr.
      if (wr_hit) begin
        shadow_d  = bus.div_data;
        pending_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q     <= '0;
        div_q     <= DIV_RST;
        shadow_q  <= DIV_RST;
        pending_q <= 1'b0;
        tick_q    <= 1'b0;
        sq_q      <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        div_q     <= div_d;
        shadow_q  <= shadow_d;
        pending_q <= pending_d;
        tick_q    <= tick_d;
        sq_q      <= sq_d;
      end
    end

    assign bus.tick[gi]    = tick_q;
    assign bus.sq[gi]      = sq_q;
    assign bus.pending[gi] = pending_q;
  end

endmodule

// File: tb/tb_tick_divider.sv
// tb_tick_divider
//   Self-checking bench for tick_divider: a table of per-edge vectors whose
//   expected outputs go through a scoreboard queue, followed by hand-written
//   multi-cycle sequences for pending divisors, run pauses, sync_clr and reset.
module tb_tick_divider;
  localparam int NCH  = 3;
  localparam int CW   = 8;
  localparam int FW   = 8;
  localparam int DDIV = 4;
  localparam int NVEC = 22;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tick_divider_if #(.NUM_CH(NCH), .CNT_W(CW), .FREE_W(FW)) bus ();

  tick_divider #(
    .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV), .FREE_W(FW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [2:0] run;
    logic       sclr;
    logic       we;
    logic [1:0] sel;
    logic [7:0] data;
    logic [2:0] e_tick;
    logic [2:0] e_sq;
    logic [2:0] e_pend;
    logic [7:0] e_free;
  } vec_t;

  typedef struct {
    int         idx;
    logic [2:0] tick;
    logic [2:0] sq;
    logic [2:0] pend;
    logic [7:0] free;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sbq [$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [2:0] r, input logic s, input logic w,
                              input logic [1:0] sel, input logic [7:0] d,
                              input logic [2:0] t, input logic [2:0] q,
                              input logic [2:0] p, input logic [7:0] f);
    vec_t v;
    v.run = r; v.sclr = s; v.we = w; v.sel = sel; v.data = d;
    v.e_tick = t; v.e_sq = q; v.e_pend = p; v.e_free = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one edge's worth of inputs, then return 1 time unit after the edge.
  task automatic cyc(input logic [2:0] r, input logic s, input logic w,
                     input logic [1:0] sel, input logic [7:0] d);
    bus.run = r; bus.sync_clr = s; bus.div_we = w; bus.div_sel = sel; bus.div_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] r);
    cyc(r, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3'b000);
    idle(3'b000);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    //                run  s  w sel  data  tick   sq     pend   free
    vecs[0]  = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b000,3'b000,8'd1);
    vecs[1]  = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b000,3'b000,8'd2);
    vecs[2]  = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b000,3'b000,8'd3);
    vecs[3]  = mk(3'b111,0,0,2'd0,8'd0, 3'b111,3'b111,3'b000,8'd4);
    vecs[4]  = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b111,3'b000,8'd5);
    vecs[5]  = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b111,3'b000,8'd6);
    vecs[6]  = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b111,3'b000,8'd7);
    vecs[7]  = mk(3'b111,0,0,2'd0,8'd0, 3'b111,3'b000,3'b000,8'd8);
    vecs[8]  = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b000,3'b000,8'd9);
    vecs[9]  = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b000,3'b000,8'd10);
    vecs[10] = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b000,3'b000,8'd11);
    vecs[11] = mk(3'b111,0,0,2'd0,8'd0, 3'b111,3'b111,3'b000,8'd12);
    // ch1 divisor 0 written, applied at the wrap on edge 16, then ticks every cycle
    vecs[12] = mk(3'b111,0,1,2'd1,8'd0, 3'b000,3'b111,3'b010,8'd13);
    vecs[13] = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b111,3'b010,8'd14);
    vecs[14] = mk(3'b111,0,0,2'd0,8'd0, 3'b000,3'b111,3'b010,8'd15);
    vecs[15] = mk(3'b111,0,0,2'd0,8'd0, 3'b111,3'b000,3'b000,8'd16);
    vecs[16] = mk(3'b111,0,0,2'd0,8'd0, 3'b010,3'b010,3'b000,8'd17);
    vecs[17] = mk(3'b111,0,0,2'd0,8'd0, 3'b010,3'b000,3'b000,8'd18);
    // ch1 divisor 1: still every cycle
    vecs[18] = mk(3'b111,0,1,2'd1,8'd1, 3'b010,3'b010,3'b010,8'd19);
    vecs[19] = mk(3'b111,0,0,2'd0,8'd0, 3'b111,3'b101,3'b000,8'd20);
    vecs[20] = mk(3'b111,0,0,2'd0,8'd0, 3'b010,3'b111,3'b000,8'd21);
    // out-of-range select: nothing becomes pending
    vecs[21] = mk(3'b111,0,1,2'd3,8'd9, 3'b010,3'b101,3'b000,8'd22);

    bus.run = '0; bus.sync_clr = 1'b0; bus.div_we = 1'b0; bus.div_sel = '0; bus.div_data = '0;
    reset = 1'b1;
    idle(3'b000);
    idle(3'b000);
    chk("reset.tick", 32'(bus.tick), 32'd0);
    chk("reset.sq", 32'(bus.sq), 32'd0);
    chk("reset.pending", 32'(bus.pending), 32'd0);
    chk("reset.free", 32'(bus.free_cnt), 32'd0);
    reset = 1'b0;

    // ---- table-driven vectors through the scoreboard ----
    for (int i = 0; i < NVEC; i++) begin
      e.idx = i; e.tick = vecs[i].e_tick; e.sq = vecs[i].e_sq;
      e.pend = vecs[i].e_pend; e.free = vecs[i].e_free;
      sbq.push_back(e);
      cyc(vecs[i].run, vecs[i].sclr, vecs[i].we, vecs[i].sel, vecs[i].data);
      e = sbq.pop_front();
      $display("vec %0d: tick=%b sq=%b pending=%b free=%0d", e.idx,
               bus.tick, bus.sq, bus.pending, bus.free_cnt);
      chk($sformatf("v%0d.tick", e.idx), 32'(bus.tick), 32'(e.tick));
      chk($sformatf("v%0d.sq", e.idx), 32'(bus.sq), 32'(e.sq));
      chk($sformatf("v%0d.pending", e.idx), 32'(bus.pending), 32'(e.pend));
      chk($sformatf("v%0d.free", e.idx), 32'(bus.free_cnt), 32'(e.free));
    end

    // ---- T3: mid-period write on ch2 does not disturb the running period ----
    do_reset();
    cyc(3'b000, 1'b0, 1'b1, 2'd2, 8'd10);
    chk("t3.pend_after_write", 32'(bus.pending[2]), 32'd1);
    cyc(3'b000, 1'b1, 1'b0, 2'd0, 8'd0);
    chk("t3.pend_after_sclr", 32'(bus.pending[2]), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      idle(3'b100);
      chk($sformatf("t3.tick_e%0d", k), 32'(bus.tick[2]), 32'd0);
    end
    cyc(3'b100, 1'b0, 1'b1, 2'd2, 8'd3);
    chk("t3.pend_midperiod", 32'(bus.pending[2]), 32'd1);
    for (int k = 5; k <= 16; k++) begin
      idle(3'b100);
      $display("t3 edge %0d: tick2=%b pending2=%b", k, bus.tick[2], bus.pending[2]);
      chk($sformatf("t3.tick_e%0d", k), 32'(bus.tick[2]),
          32'((k == 10 || k == 13 || k == 16) ? 1 : 0));
      chk($sformatf("t3.pend_e%0d", k), 32'(bus.pending[2]), 32'((k < 10) ? 1 : 0));
    end

    // ---- T4: run pause holds the count ----
    do_reset();
    cyc(3'b000, 1'b0, 1'b1, 2'd0, 8'd6);
    cyc(3'b000, 1'b1, 1'b0, 2'd0, 8'd0);
    idle(3'b001);
    idle(3'b001);
    for (int k = 1; k <= 5; k++) begin
      idle(3'b000);
      chk($sformatf("t4.pause_tick%0d", k), 32'(bus.tick[0]), 32'd0);
      chk($sformatf("t4.pause_sq%0d", k), 32'(bus.sq[0]), 32'd0);
    end
    for (int k = 1; k <= 4; k++) begin
      idle(3'b001);
      $display("t4 resumed edge %0d: tick0=%b", k, bus.tick[0]);
      chk($sformatf("t4.resume_tick%0d", k), 32'(bus.tick[0]), 32'((k == 4) ? 1 : 0));
    end
    chk("t4.sq_after", 32'(bus.sq[0]), 32'd1);

    // ---- T5: sync_clr phase-aligns channels; simultaneous write stays pending ----
    do_reset();
    cyc(3'b000, 1'b0, 1'b1, 2'd0, 8'd5);
    cyc(3'b000, 1'b0, 1'b1, 2'd1, 8'd7);
    cyc(3'b000, 1'b1, 1'b0, 2'd0, 8'd0);
    for (int k = 1; k <= 5; k++) idle(3'b001);
    chk("t5.ch0_sq_before", 32'(bus.sq[0]), 32'd1);
    idle(3'b010);
    idle(3'b010);
    for (int k = 1; k <= 3; k++) idle(3'b011);
    cyc(3'b011, 1'b1, 1'b1, 2'd0, 8'd2);
    chk("t5.sclr_tick", 32'(bus.tick[1:0]), 32'd0);
    chk("t5.sclr_sq", 32'(bus.sq[1:0]), 32'd0);
    chk("t5.sclr_pend", 32'(bus.pending), 32'b001);
    for (int k = 1; k <= 7; k++) begin
      idle(3'b011);
      $display("t5 edge %0d: tick=%b pending=%b", k, bus.tick, bus.pending);
      chk($sformatf("t5.tick0_e%0d", k), 32'(bus.tick[0]), 32'((k == 5 || k == 7) ? 1 : 0));
      chk($sformatf("t5.tick1_e%0d", k), 32'(bus.tick[1]), 32'((k == 7) ? 1 : 0));
      chk($sformatf("t5.pend0_e%0d", k), 32'(bus.pending[0]), 32'((k < 5) ? 1 : 0));
    end
    cyc(3'b000, 1'b0, 1'b1, 2'd3, 8'd1);
    chk("t5.bad_sel_pend", 32'(bus.pending), 32'd0);

    // ---- T6: reset mid-period with a pending write; free counter wrap ----
    do_reset();
    idle(3'b111);
    idle(3'b111);
    cyc(3'b111, 1'b0, 1'b1, 2'd1, 8'd9);
    chk("t6.pend_before", 32'(bus.pending), 32'b010);
    reset = 1'b1;
    idle(3'b111);
    chk("t6.tick", 32'(bus.tick), 32'd0);
    chk("t6.sq", 32'(bus.sq), 32'd0);
    chk("t6.pending", 32'(bus.pending), 32'd0);
    chk("t6.free", 32'(bus.free_cnt), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idle(3'b010);
      chk($sformatf("t6.tick1_e%0d", k), 32'(bus.tick[1]), 32'((k == 4) ? 1 : 0));
    end
    for (int k = 1; k <= 251; k++) idle(3'b000);
    chk("t6.free_max", 32'(bus.free_cnt), 32'd255);
    idle(3'b000);
    chk("t6.free_wrap", 32'(bus.free_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
